// File: rtl/lfsr_rng_stream_if.sv
// Random-word stream: producer drives out_data/out_valid; consumer drives out_ready.
interface lfsr_rng_stream_if #(
  parameter int OUT_W = 12
);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/lfsr_rng_stream.sv
// Fibonacci-LFSR word generator: OUT_W bits per word, LSB first, one step per clock; word valid OUT_W+1 cycles after en.
// out_ready low holds the word and freezes the LFSR; seed_load aborts any word in flight and drops a pending one.
module lfsr_rng_stream #(
  parameter int                LFSR_W     = 32,
  parameter int                OUT_W      = 12,
  parameter logic [LFSR_W-1:0] TAPS       = 32'h80200003,
  parameter logic [LFSR_W-1:0] RESET_SEED = 32'h00000001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_val,
  lfsr_rng_stream_if.master strm,
  output logic              busy,
  output logic [LFSR_W-1:0] lfsr_state
);

  localparam int              CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    VALID
  } state_t;

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [OUT_W-1:0]  acc, acc_nxt;
  logic [OUT_W-1:0]  data, data_nxt;
  logic [OUT_W-1:0]  word;
  logic              fb;

  assign fb        = ^(lfsr & TAPS);
  assign lfsr_step = {fb, lfsr[LFSR_W-1:1]};

  // Bits collect in acc so out_data keeps the previous word until the new one is complete.
  always_comb begin
    word      = acc;
    word[cnt] = lfsr[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lfsr  <= RESET_SEED;
      cnt   <= '0;
      acc   <= '0;
      data  <= '0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      data  <= data_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    data_nxt  = data;
    if (seed_load) begin
      // A zero seed would lock the LFSR at zero forever.
      lfsr_nxt  = (seed_val == '0) ? LFSR_W'(1) : seed_val;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state_nxt = GEN;
            cnt_nxt   = '0;
          end
        end
        GEN: begin
          lfsr_nxt = lfsr_step;
          acc_nxt  = word;
          if (cnt == LAST) begin
            data_nxt  = word;
            cnt_nxt   = '0;
            state_nxt = VALID;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        VALID: begin
          if (strm.out_ready) begin
            state_nxt = en ? GEN : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign strm.out_valid = (state == VALID);
  assign strm.out_data  = data;
  assign busy           = (state == GEN);
  assign lfsr_state     = lfsr;

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Directed and randomized checks of lfsr_rng_stream against an arithmetic LFSR reference model.
module tb_lfsr_rng_stream;
  localparam int          LFSR_W = 8;
  localparam int          OUT_W  = 4;
  localparam int unsigned TAPS_M = 32'h03;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              seed_load;
  logic [LFSR_W-1:0] seed_val;
  logic              busy;
  logic [LFSR_W-1:0] lfsr_state;

  lfsr_rng_stream_if #(.OUT_W(OUT_W)) strm ();

  lfsr_rng_stream #(
    .LFSR_W    (LFSR_W),
    .OUT_W     (OUT_W),
    .TAPS      (8'h03),
    .RESET_SEED(8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .seed_load (seed_load),
    .seed_val  (seed_val),
    .strm      (strm),
    .busy      (busy),
    .lfsr_state(lfsr_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned m_state;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: shift right, feedback parity of tapped bits enters the MSB.
  function automatic int unsigned ref_step(input int unsigned s);
    int unsigned fb;
    fb = $countones(s & TAPS_M) % 2;
    return (s >> 1) + fb * (2 ** (LFSR_W - 1));
  endfunction

  task automatic ref_word(output int unsigned w);
    w = 0;
    for (int i = 0; i < OUT_W; i++) begin
      w       = w + ((m_state % 2) << i);
      m_state = ref_step(m_state);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_word(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (strm.out_valid !== 1'b1 && n < 40);
    check("word_timeout", {31'b0, strm.out_valid}, 32'd1);
  endtask

  task automatic check_word(input string tag);
    int unsigned w;
    ref_word(w);
    check({tag, "_data"}, {28'b0, strm.out_data}, w);
    check({tag, "_lfsr"}, {24'b0, lfsr_state}, m_state);
  endtask

  task automatic stream3(input string tag);
    int n;
    for (int k = 0; k < 3; k++) begin
      wait_word(n);
      check({tag, "_period"}, n, 32'd5);
      check_word(tag);
      if (k == 2) en = 1'b0;
    end
    tick();
    check({tag, "_end_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_end_valid"}, {31'b0, strm.out_valid}, 32'd0);
  endtask

  initial begin
    int                n;
    int                seen;
    int                stall;
    logic [OUT_W-1:0]  d;
    logic [LFSR_W-1:0] l;
    logic [LFSR_W-1:0] sv;

    rst            = 1'b1;
    en             = 1'b0;
    seed_load      = 1'b0;
    seed_val       = '0;
    strm.out_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'b0, strm.out_valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_lfsr", {24'b0, lfsr_state}, 32'h01);
    check("rst_data", {28'b0, strm.out_data}, 32'd0);
    rst = 1'b0;

    // Stream from seed 1
    seed_val  = 8'h01;
    seed_load = 1'b1;
    tick();
    seed_load      = 1'b0;
    m_state        = 1;
    en             = 1'b1;
    strm.out_ready = 1'b1;
    stream3("stream");

    // Zero seed is replaced by 1
    seed_val  = 8'h00;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("zero_seed_lfsr", {24'b0, lfsr_state}, 32'h01);
    m_state = 1;
    en      = 1'b1;
    stream3("zseed");

    // Back-pressure
    en             = 1'b1;
    strm.out_ready = 1'b0;
    wait_word(n);
    check("bp_lat", n, 32'd5);
    check_word("bp");
    d = strm.out_data;
    l = lfsr_state;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", {31'b0, strm.out_valid}, 32'd1);
      check("bp_data", {28'b0, strm.out_data}, {28'b0, d});
      check("bp_lfsr", {24'b0, lfsr_state}, {24'b0, l});
      check("bp_busy", {31'b0, busy}, 32'd0);
    end
    strm.out_ready = 1'b1;
    en             = 1'b0;
    tick();
    check("bp_accept_once", {31'b0, strm.out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += int'(strm.out_valid);
    end
    check("bp_no_more", seen, 32'd0);

    // Abort at GEN step 2
    en = 1'b1;
    tick();
    tick();
    tick();
    check("abort_busy", {31'b0, busy}, 32'd1);
    seed_val  = 8'h01;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("abort_lfsr", {24'b0, lfsr_state}, 32'h01);
    check("abort_valid", {31'b0, strm.out_valid}, 32'd0);
    check("abort_busy_off", {31'b0, busy}, 32'd0);
    m_state = 1;
    wait_word(n);
    check("abort_lat", n, 32'd5);
    check_word("abort");
    en = 1'b0;
    tick();
    check("abort_drop", {31'b0, strm.out_valid}, 32'd0);

    // en low mid-word: word still completes
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_word(n);
    check("enlow_lat", n, 32'd4);
    check_word("enlow");
    tick();
    check("enlow_busy", {31'b0, busy}, 32'd0);
    check("enlow_valid", {31'b0, strm.out_valid}, 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += int'(strm.out_valid);
    end
    check("enlow_idle", seen, 32'd0);

    // Randomized seeds and stalls
    for (int it = 0; it < 20; it++) begin
      sv        = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      seed_val  = sv;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      m_state   = (sv == 8'h00) ? 1 : int'(sv);
      check("rnd_seed", {24'b0, lfsr_state}, m_state);
      stall          = $urandom_range(0, 4);
      strm.out_ready = (stall == 0);
      en             = 1'b1;
      wait_word(n);
      check("rnd_lat", n, 32'd5);
      check_word("rnd");
      d = strm.out_data;
      for (int s = 0; s < stall; s++) begin
        tick();
        check("rnd_hold", {28'b0, strm.out_data}, {28'b0, d});
      end
      strm.out_ready = 1'b1;
      en             = 1'b0;
      tick();
      check("rnd_drop", {31'b0, strm.out_valid}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
